uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_receiver.sv | 176 +++++++++++++++++
 tb/tb_uart_receiver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// UART receiver: 2-flop synchronized serial input, start/data/two-stop framing,
// and a show-ahead receive buffer with frame-error and overrun pulses.
module uart_receiver #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        RXserial,
  input  logic                        rd,
  output logic [WIDTH-1:0]            data_out,
  output logic                        valid,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  output logic [DEPTH-1:0][WIDTH-1:0] RXBUF,
  output logic                        frame_err,
  output logic                        overrun,
  output logic                        busy
);

  localparam int CNTW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDXW = $clog2(WIDTH + 1);
  localparam int CW   = $clog2(DEPTH) + 1;

  localparam logic [CNTW-1:0] HALF_M1 = CNTW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] BIT_M1  = CNTW'(CLKS_PER_BIT - 1);
  localparam logic [IDXW-1:0] LAST_IX = IDXW'(WIDTH - 1);
  localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP1 = 3'd3;
  localparam logic [2:0] S_STOP2 = 3'd4;

  logic                        rx_meta_q, rx_s_q, rx_d_q;
  logic [2:0]                  state_q, state_d;
  logic [CNTW-1:0]             cnt_q, cnt_d;
  logic [IDXW-1:0]             idx_q, idx_d;
  logic [WIDTH-1:0]            sh_q, sh_d;
  logic [DEPTH-1:0][WIDTH-1:0] buf_q, buf_d;
  logic [CW-1:0]               count_q, count_d;
  logic                        frame_err_q, frame_err_d;
  logic                        overrun_q, overrun_d;
  logic                        push, pop;

  // Framing state machine; all decisions use the synchronized line.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rx_d_q && !rx_s_q) begin
          cnt_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_q == HALF_M1) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          sh_d  = {rx_s_q, sh_q[WIDTH-1:1]};
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST_IX) state_d = S_STOP1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP1: begin
        if (cnt_q == BIT_M1) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_STOP2;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP2: begin
        if (cnt_q == BIT_M1) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          if (rx_s_q) push = 1'b1;
          else        frame_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Buffer: pop shifts toward entry 0, push appends at the first free slot.
  always_comb begin
    buf_d     = buf_q;
    count_d   = count_q;
    overrun_d = 1'b0;
    pop       = rd && (count_q != '0);
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) buf_d[i] = buf_q[i+1];
      buf_d[DEPTH-1] = '0;
      count_d        = count_q - 1'b1;
    end
    if (push) begin
      if (pop || (count_q != DEPTH_C)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (CW'(i) == count_d) buf_d[i] = sh_q;
        end
        count_d = count_d + 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_d_q      <= 1'b1;
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      sh_q        <= '0;
      // NOTE: the buffer is reset because its image is a visible output that must read zero.
      buf_q       <= '0;
      count_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      rx_meta_q   <= RXserial;
      rx_s_q      <= rx_meta_q;
      rx_d_q      <= rx_s_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out  = buf_q[0];
  assign RXBUF     = buf_q;
  assign count     = count_q;
  assign valid     = (count_q != '0);
  assign full      = (count_q == DEPTH_C);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver (WIDTH=8, DEPTH=4, CLKS_PER_BIT=16):
// frames are bit-banged on RXserial and outputs compared to hand-computed values.
module tb_uart_receiver;

  localparam int CPB = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             RXserial;
  logic             rd;
  logic [7:0]       data_out;
  logic             valid, full, frame_err, overrun, busy;
  logic [2:0]       count;
  logic [3:0][7:0]  RXBUF;

  int errors = 0;
  int total  = 0;
  int ferr_n = 0;
  int ovr_n  = 0;

  uart_receiver #(.WIDTH(8), .DEPTH(4), .CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .RXserial  (RXserial),
    .rd        (rd),
    .data_out  (data_out),
    .valid     (valid),
    .full      (full),
    .count     (count),
    .RXBUF     (RXBUF),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output.
  always @(negedge clk) begin
    if (frame_err) ferr_n++;
    if (overrun)   ovr_n++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    RXserial = b;
    repeat (CPB) tick();
  endtask

  task automatic send_head(input logic [7:0] d, input logic s1);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(s1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s1, input logic s2);
    send_head(d, s1);
    drive_bit(s2);
  endtask

  task automatic pop();
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    RXserial = 1'b1;
    rd       = 1'b0;
    repeat (3) tick();
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_full",  {31'd0, full},  32'd0);
    check("rst_dout",  {24'd0, data_out}, 32'd0);
    check("rst_rxbuf", RXBUF, 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    // rd while empty is ignored
    pop();
    check("rd_empty_count", {29'd0, count}, 32'd0);

    // single frame 0xA5; valid must rise exactly one cycle after the STOP2 sample
    send_head(8'hA5, 1'b1);
    RXserial = 1'b1;
    repeat (10) tick();
    check("a5_valid_before", {31'd0, valid}, 32'd0);
    tick();
    check("a5_valid_after", {31'd0, valid}, 32'd1);
    check("a5_dout",  {24'd0, data_out}, 32'hA5);
    check("a5_count", {29'd0, count}, 32'd1);
    repeat (5) tick();
    pop();
    check("a5_pop_count", {29'd0, count}, 32'd0);
    check("a5_pop_valid", {31'd0, valid}, 32'd0);
    check("a5_pop_dout",  {24'd0, data_out}, 32'd0);

    // 4-cycle glitch on an idle line
    RXserial = 1'b0;
    repeat (4) tick();
    RXserial = 1'b1;
    repeat (3) tick();
    check("glitch_busy_hi", {31'd0, busy}, 32'd1);
    repeat (20) tick();
    check("glitch_busy_lo", {31'd0, busy}, 32'd0);
    check("glitch_count", {29'd0, count}, 32'd0);
    check("glitch_ferr", ferr_n, 32'd0);

    // five back-to-back frames, no reads: fifth overruns
    for (int f = 1; f <= 5; f++) send_frame(8'(f), 1'b1, 1'b1);
    check("five_rxbuf", RXBUF, 32'h04030201);
    check("five_full",  {31'd0, full}, 32'd1);
    check("five_count", {29'd0, count}, 32'd4);
    check("five_ovr",   ovr_n, 32'd1);

    // full buffer, rd on the push cycle of 0x99
    send_head(8'h99, 1'b1);
    RXserial = 1'b1;
    repeat (10) tick();
    rd = 1'b1;
    tick();
    rd = 1'b0;
    repeat (5) tick();
    check("rdpush_count", {29'd0, count}, 32'd4);
    check("rdpush_rxbuf", RXBUF, 32'h99040302);
    check("rdpush_ovr",   ovr_n, 32'd1);

    // drain in order
    check("drain0", {24'd0, data_out}, 32'h02);
    pop();
    check("drain1", {24'd0, data_out}, 32'h03);
    pop();
    check("drain2", {24'd0, data_out}, 32'h04);
    pop();
    check("drain3", {24'd0, data_out}, 32'h99);
    pop();
    check("drain_count", {29'd0, count}, 32'd0);
    check("drain_rxbuf", RXBUF, 32'd0);

    // STOP1 low on 0x3C, then a good 0x7E
    send_frame(8'h3C, 1'b0, 1'b1);
    check("ferr_pulse", ferr_n, 32'd1);
    check("ferr_count", {29'd0, count}, 32'd0);
    send_frame(8'h7E, 1'b1, 1'b1);
    check("after_ferr_dout",  {24'd0, data_out}, 32'h7E);
    check("after_ferr_count", {29'd0, count}, 32'd1);
    check("after_ferr_pulse", ferr_n, 32'd1);

    // reset during DATA bit 4 of 0xC3 (buffer still holds 0x7E)
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'hC3 >> i));
    RXserial = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #2;
    check("midrst_busy",  {31'd0, busy},  32'd0);
    check("midrst_count", {29'd0, count}, 32'd0);
    check("midrst_valid", {31'd0, valid}, 32'd0);
    check("midrst_dout",  {24'd0, data_out}, 32'd0);
    check("midrst_rxbuf", RXBUF, 32'd0);
    RXserial = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (20) tick();
    check("postrst_busy",  {31'd0, busy},  32'd0);
    check("postrst_count", {29'd0, count}, 32'd0);
    check("postrst_pulses", ferr_n + ovr_n, 32'd2);
    send_frame(8'h55, 1'b1, 1'b1);
    check("postrst_dout",  {24'd0, data_out}, 32'h55);
    check("postrst_count1", {29'd0, count}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, total);
    $finish;
  end

endmodule
